// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte/valid/ready plus the error pulses.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    modport master (
        output data, valid, frame_err, overrun, parity_err,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, overrun, parity_err,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling with a down-counting baud timer.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | confirming the start bit at its mid-point
// DATA      | sampling data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, delivering the byte
// WAIT_HIGH | bad stop / break: waiting for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic                 rx_m;
    logic                 rx_s;
    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 ov_q;
    logic                 tick;

    // Both stages reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (timer == '0);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic pe_q;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q  <= 1'b0;
`endif
            timer <= tick ? FULL : timer - 1'b1;
            if (valid_q && bus.ready)
                valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        timer <= HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            timer   <= FULL;
                            bit_idx <= LAST;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx - 1'b1;
                        if (bit_idx == '0)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad <= ^{shreg, rx_s};
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                            // An unaccepted byte wins; the new one is dropped.
                            if (!valid_q || bus.ready) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end else begin
                                ov_q <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            pe_q <= par_bad;
`endif
                        end else begin
                            fe_q  <= 1'b1;
                            state <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = pe_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16, DATA_BITS=8; honours UART_RX_PARITY_EN.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + (DB + 1 + P) * CPB;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic rx = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk    (clk),
        .nreset (nreset),
        .rx     (rx),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts only, sampled on the falling edge.
    int vld_hi = 0, vld_rise = 0, rise_cyc = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic valid_d = 1'b0;
    logic [7:0] acc_q[$];
    always @(negedge clk) begin
        if (bus.valid === 1'b1) vld_hi <= vld_hi + 1;
        if (bus.valid === 1'b1 && valid_d !== 1'b1) begin
            vld_rise <= vld_rise + 1;
            rise_cyc <= cyc;
        end
        if (bus.frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
        if (bus.overrun === 1'b1)    ov_cnt <= ov_cnt + 1;
        if (bus.parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
        if (bus.valid === 1'b1 && bus.ready === 1'b1) acc_q.push_back(bus.data);
        valid_d <= bus.valid;
    end

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int b_hi, b_rise, b_fe, b_ov, b_pe, b_acc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_hi = vld_hi; b_rise = vld_rise; b_fe = fe_cnt;
        b_ov = ov_cnt; b_pe = pe_cnt; b_acc = acc_q.size();
    endtask

    // Drive one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        start_cyc = cyc;
        wait_clk(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        if (P == 1) begin
            rx = par_bit;
            wait_clk(CPB);
        end
        rx = stop_bit;
        wait_clk(CPB);
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    typedef struct {
        logic [7:0] b;
        logic       stop_bit;
        int         exp_rise;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] exp_q[$];
    int exp_fe, exp_pe;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h11, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1};
        vecs[6] = '{8'h01, 1'b1, 1, 0};

        bus.ready = 1'b1;
        wait_clk(3);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_data", int'(bus.data), 0);
        chk("reset_flags", int'({bus.frame_err, bus.overrun, bus.parity_err}), 0);
        nreset = 1'b1;
        wait_clk(5);

        // Table-driven frames with ready held high.
        for (int v = 0; v < 7; v++) begin
            snap();
            send_frame(vecs[v].b, vecs[v].stop_bit, even_par(vecs[v].b));
            if (!vecs[v].stop_bit) wait_clk(40);
            rx = 1'b1;
            wait_clk(30);
            chk($sformatf("vec%0d_valid_rise", v), vld_rise - b_rise, vecs[v].exp_rise);
            chk($sformatf("vec%0d_valid_cycles", v), vld_hi - b_hi, vecs[v].exp_rise);
            chk($sformatf("vec%0d_frame_err", v), fe_cnt - b_fe, vecs[v].exp_fe);
            chk($sformatf("vec%0d_flags", v), (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);
            if (vecs[v].exp_rise == 1) begin
                chk($sformatf("vec%0d_latency", v), rise_cyc - start_cyc - 1, LAT);
                if (acc_q.size() > b_acc)
                    chk($sformatf("vec%0d_data", v), int'(acc_q[acc_q.size()-1]), int'(vecs[v].b));
                else
                    chk($sformatf("vec%0d_data_missing", v), acc_q.size() - b_acc, 1);
            end
        end

        // Glitch shorter than half a bit, then a normal frame still lands on time.
        snap();
        rx = 1'b0;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(40);
        chk("glitch_valid", vld_rise - b_rise, 0);
        chk("glitch_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);
        send_frame(8'h96, 1'b1, even_par(8'h96));
        wait_clk(20);
        chk("post_glitch_latency", rise_cyc - start_cyc - 1, LAT);

        // Overrun: two back-to-back bytes with ready low.
        bus.ready = 1'b0;
        snap();
        send_frame(8'h01, 1'b1, even_par(8'h01));
        send_frame(8'h02, 1'b1, even_par(8'h02));
        wait_clk(20);
        chk("ovr_valid", int'(bus.valid), 1);
        chk("ovr_data", int'(bus.data), 8'h01);
        chk("ovr_pulse", ov_cnt - b_ov, 1);
        bus.ready = 1'b1;
        wait_clk(3);
        chk("ovr_valid_clear", int'(bus.valid), 0);
        chk("ovr_accepted", acc_q.size() - b_acc, 1);

        // Reset after the 4th data bit of 0xFF.
        snap();
        rx = 1'b0;
        wait_clk(CPB);
        rx = 1'b1;
        wait_clk(4 * CPB + 2);
        nreset = 1'b0;
        wait_clk(3);
        chk("rst_mid_valid", int'(bus.valid), 0);
        nreset = 1'b1;
        wait_clk(6 * CPB);
        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        wait_clk(20);
        chk("rst_mid_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);
        chk("rst_mid_rise", vld_rise - b_rise, 1);
        if (acc_q.size() > b_acc)
            chk("rst_mid_data", int'(acc_q[acc_q.size()-1]), 8'h5A);
        else
            chk("rst_mid_data_missing", acc_q.size() - b_acc, 1);

        if (P == 1) begin
            snap();
            send_frame(8'h07, 1'b1, 1'b1);
            wait_clk(10);
            send_frame(8'h07, 1'b1, 1'b0);
            wait_clk(20);
            chk("par_rise", vld_rise - b_rise, 2);
            chk("par_err", pe_cnt - b_pe, 1);
            if (acc_q.size() > b_acc)
                chk("par_data", int'(acc_q[acc_q.size()-1]), 8'h07);
        end

        // Random frames against a frame-level model (ready high).
        snap();
        exp_q.delete();
        exp_fe = 0;
        exp_pe = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic stop_bit, flip;
            b = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            flip = (P == 1) && ($urandom_range(0, 3) == 0);
            send_frame(b, stop_bit, even_par(b) ^ flip);
            if (stop_bit) begin
                exp_q.push_back(b);
                if (flip) exp_pe++;
                wait_clk($urandom_range(0, 12));
            end else begin
                exp_fe++;
                wait_clk($urandom_range(0, 30));
                rx = 1'b1;
                wait_clk($urandom_range(1, 12));
            end
        end
        rx = 1'b1;
        wait_clk(40);
        chk("rand_count", acc_q.size() - b_acc, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (b_acc + i < acc_q.size())
                chk($sformatf("rand_data%0d", i), int'(acc_q[b_acc+i]), int'(exp_q[i]));
        chk("rand_frame_err", fe_cnt - b_fe, exp_fe);
        chk("rand_parity_err", pe_cnt - b_pe, exp_pe);
        chk("rand_overrun", ov_cnt - b_ov, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
